// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int FETCH_D          = 12;
    localparam int FETCH_LW         = 3;
    localparam int FETCH_SD         = 4;
    localparam int FETCH_WW         = 16;
    localparam int FETCH_START_ADDR = 0;
    localparam int FETCH_END_ADDR   = 128;

    // Encoding keeps run and done as individual state bits.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } fetch_state_e;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_RET,
        SEL_CALL,
        SEL_ABS,
        SEL_REL,
        SEL_INC
    } pc_sel_e;

endpackage

// File: rtl/fetch_stack.sv
// Return-address LIFO for the fetch sequencer; holds SD entries of D bits.
module fetch_stack
    import fetch_pkg::*;
#(
    parameter int D  = FETCH_D,
    parameter int SD = FETCH_SD
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [D-1:0] i_data,
    output logic [D-1:0] o_top,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (SD > 1) ? $clog2(SD) : 1;
    localparam int CW = $clog2(SD + 1);

    logic [D-1:0]  r_mem [SD];
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_wr_idx = AW'(r_cnt);
    assign w_rd_idx = AW'(r_cnt - CW'(1));
    assign o_full   = (r_cnt == CW'(SD));
    assign o_empty  = (r_cnt == '0);
    // Top is only meaningful when not empty; the caller gates pops on o_empty.
    assign o_top    = r_mem[w_rd_idx];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
            for (int i = 0; i < SD; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_cnt <= '0;
        end else if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
            r_cnt           <= r_cnt + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: PC, jump LUT, run/done handshake and watchdog.
// Optional call/return stack enabled by defining FETCH_SEQ_CALL_STACK_EN.
//
// state | meaning
// IDLE  | after reset, PC at start address, waiting for req
// RUN   | fetching, one PC update per cycle
// DONE  | run ended (end address, halt or fault), waiting for req
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int D          = FETCH_D,
    parameter int LW         = FETCH_LW,
    parameter int SD         = FETCH_SD,
    parameter int WW         = FETCH_WW,
    parameter int START_ADDR = FETCH_START_ADDR,
    parameter int END_ADDR   = FETCH_END_ADDR
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req,
    input  logic          i_halt,
    input  logic          i_relj,
    input  logic          i_absj,
    input  logic          i_call_en,
    input  logic          i_ret_en,
    input  logic [LW-1:0] i_lut_idx,
    input  logic          i_lut_we,
    input  logic [LW-1:0] i_lut_widx,
    input  logic [D-1:0]  i_lut_wdat,
    output logic [D-1:0]  o_prog_ctr,
    output logic          o_run,
    output logic          o_done,
    output logic          o_fault,
    output logic [WW-1:0] o_cyc_cnt
);

    localparam logic [1:0]   S_IDLE  = ST_IDLE;
    localparam logic [1:0]   S_RUN   = ST_RUN;
    localparam logic [1:0]   S_DONE  = ST_DONE;
    localparam logic [D-1:0] L_START = D'(START_ADDR);
    localparam logic [D-1:0] L_END   = D'(END_ADDR);

    logic [1:0]    r_state;
    logic [D-1:0]  r_pc;
    logic          r_fault;
    logic [WW-1:0] r_cnt;
    logic [D-1:0]  r_lut [2**LW];

    pc_sel_e       w_sel;
    logic [D-1:0]  w_lut_rd;
    logic [D-1:0]  w_pc_inc;
    logic [D-1:0]  w_next_pc;
    logic [D-1:0]  w_stk_top;
    logic [WW-1:0] w_cnt_next;
    logic          w_in_run;
    logic          w_start;
    logic          w_wdog;
    logic          w_stk_fault;
    logic          w_advance;
    logic          w_end_hit;
    logic          w_term;

    assign w_in_run   = (r_state == S_RUN);
    assign w_start    = !w_in_run && i_req;
    assign w_lut_rd   = r_lut[i_lut_idx];
    assign w_pc_inc   = r_pc + D'(1);
    assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + WW'(1);
    assign w_wdog     = (w_cnt_next == '1);

    always_comb begin
        w_sel = SEL_INC;
        if (i_halt)
            w_sel = SEL_HOLD;
`ifdef FETCH_SEQ_CALL_STACK_EN
        else if (i_ret_en)
            w_sel = SEL_RET;
        else if (i_call_en)
            w_sel = SEL_CALL;
`endif
        else if (i_absj)
            w_sel = SEL_ABS;
        else if (i_relj)
            w_sel = SEL_REL;
    end

    // Relative offsets are two's complement; modulo-2**D addition handles sign.
    always_comb begin
        w_next_pc = w_pc_inc;
        case (w_sel)
            SEL_HOLD: w_next_pc = r_pc;
            SEL_RET:  w_next_pc = w_stk_top;
            SEL_CALL: w_next_pc = w_lut_rd;
            SEL_ABS:  w_next_pc = w_lut_rd;
            SEL_REL:  w_next_pc = r_pc + w_lut_rd;
            default:  w_next_pc = w_pc_inc;
        endcase
    end

`ifdef FETCH_SEQ_CALL_STACK_EN
    logic w_stk_full;
    logic w_stk_empty;

    fetch_stack #(
        .D  (D),
        .SD (SD)
    ) u_stack (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_in_run && (w_sel == SEL_CALL) && !w_stk_full),
        .i_pop   (w_in_run && (w_sel == SEL_RET) && !w_stk_empty),
        .i_flush (w_start),
        .i_data  (w_pc_inc),
        .o_top   (w_stk_top),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    assign w_stk_fault = ((w_sel == SEL_RET) && w_stk_empty) ||
                         ((w_sel == SEL_CALL) && w_stk_full);
`else
    logic w_unused_ctl;

    assign w_stk_top    = '0;
    assign w_stk_fault  = 1'b0;
    assign w_unused_ctl = i_call_en ^ i_ret_en ^ (SD > 0);
`endif

    assign w_advance = (w_sel != SEL_HOLD) && !w_stk_fault;
    assign w_end_hit = w_advance && (w_next_pc == L_END);
    assign w_term    = (w_sel == SEL_HOLD) || w_stk_fault || w_wdog || w_end_hit;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= L_START;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_cnt <= w_cnt_next;
                    if (w_advance)
                        r_pc <= w_next_pc;
                    if (w_stk_fault || w_wdog)
                        r_fault <= 1'b1;
                    if (w_term)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    if (i_req) begin
                        r_state <= S_RUN;
                        r_pc    <= L_START;
                        r_cnt   <= '0;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    if (i_req)
                        r_state <= S_RUN;
                end
            endcase
        end
    end

    // Reads are combinational from the array, so a same-cycle write is not seen.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < 2**LW; i++) begin
                r_lut[i] <= '0;
            end
        end else if (i_lut_we) begin
            r_lut[i_lut_widx] <= i_lut_wdat;
        end
    end

    assign o_prog_ctr = r_pc;
    assign o_run      = r_state[0];
    assign o_done     = r_state[1];
    assign o_fault    = r_fault;
    assign o_cyc_cnt  = r_cnt;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed and randomized checks of fetch_seq against a behavioural model.
module tb_fetch_seq;

    localparam int SD    = 2;
    localparam int WMAX  = 65535;
    localparam int PCMOD = 4096;
    localparam int ENDA  = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, halt, relj, absj, call_en, ret_en, lut_we;
    logic [2:0]  lut_idx, lut_widx;
    logic [11:0] lut_wdat;

    logic [11:0] pc, wd_pc;
    logic        run, done, fault, wd_run, wd_done, wd_fault;
    logic [15:0] cyc;
    logic [3:0]  wd_cyc;

    int n_checks = 0;
    int n_errors = 0;

    bit m_run, m_done, m_fault;
    int m_pc, m_cnt;
    int m_lut [8];
    int m_stk [$];

    always #5 clk = ~clk;

    fetch_seq #(.SD(SD)) u_dut (
        .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_halt(halt),
        .i_relj(relj), .i_absj(absj), .i_call_en(call_en), .i_ret_en(ret_en),
        .i_lut_idx(lut_idx), .i_lut_we(lut_we), .i_lut_widx(lut_widx),
        .i_lut_wdat(lut_wdat), .o_prog_ctr(pc), .o_run(run), .o_done(done),
        .o_fault(fault), .o_cyc_cnt(cyc)
    );

    fetch_seq #(.SD(SD), .WW(4)) u_wd (
        .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_halt(halt),
        .i_relj(relj), .i_absj(absj), .i_call_en(call_en), .i_ret_en(ret_en),
        .i_lut_idx(lut_idx), .i_lut_we(lut_we), .i_lut_widx(lut_widx),
        .i_lut_wdat(lut_wdat), .o_prog_ctr(wd_pc), .o_run(wd_run), .o_done(wd_done),
        .o_fault(wd_fault), .o_cyc_cnt(wd_cyc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},    32'(pc),    m_pc);
        chk({tag, ".run"},   32'(run),   32'(m_run));
        chk({tag, ".done"},  32'(done),  32'(m_done));
        chk({tag, ".fault"}, 32'(fault), 32'(m_fault));
        chk({tag, ".cyc"},   32'(cyc),   m_cnt);
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_fault = 0; m_pc = 0; m_cnt = 0;
        for (int i = 0; i < 8; i++) m_lut[i] = 0;
        m_stk.delete();
    endtask

    task automatic clear_ctl();
        req = 0; halt = 0; relj = 0; absj = 0; call_en = 0; ret_en = 0;
        lut_idx = 0; lut_we = 0; lut_widx = 0; lut_wdat = 0;
    endtask

    // Model one clock edge from the currently driven inputs, then compare.
    task automatic step(input string tag);
        int rd, tgt, ncnt;
        bit adv, term;
        rd = m_lut[lut_idx];
        if (m_run) begin
            ncnt = (m_cnt == WMAX) ? m_cnt : m_cnt + 1;
            term = 0;
            if (halt) begin
                term = 1;
            end else begin
                adv = 1;
                tgt = (m_pc + 1) % PCMOD;
                if (absj) tgt = rd;
                else if (relj) tgt = (m_pc + rd) % PCMOD;
`ifdef FETCH_SEQ_CALL_STACK_EN
                if (ret_en) begin
                    if (m_stk.size() == 0) begin adv = 0; m_fault = 1; term = 1; end
                    else tgt = m_stk.pop_back();
                end else if (call_en) begin
                    if (m_stk.size() == SD) begin adv = 0; m_fault = 1; term = 1; end
                    else begin m_stk.push_back((m_pc + 1) % PCMOD); tgt = rd; end
                end
`endif
                if (adv) begin
                    m_pc = tgt;
                    if (tgt == ENDA) term = 1;
                end
            end
            m_cnt = ncnt;
            if (ncnt == WMAX) begin m_fault = 1; term = 1; end
            if (term) begin m_run = 0; m_done = 1; end
        end else if (req) begin
            if (m_done) begin
                m_pc = 0; m_cnt = 0; m_fault = 0;
                m_stk.delete();
            end
            m_run = 1; m_done = 0;
        end
        if (lut_we) m_lut[lut_widx] = int'(lut_wdat);
        @(posedge clk);
        #1;
        check_model(tag);
        clear_ctl();
    endtask

    task automatic lut_write(input int idx, input int val);
        lut_we = 1; lut_widx = 3'(idx); lut_wdat = 12'(val);
        step("lutw");
    endtask

    initial begin
        #300000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        clear_ctl();
        rst_n = 0;
        model_reset();
        #12;
        check_model("reset");
        chk("reset.pc0", 32'(pc), 0);
        rst_n = 1;

        // Start and walk to the end address
        req = 1;
        step("start");
        chk("start.run", 32'(run), 1);
        for (int i = 0; i < ENDA; i++) step("walk");
        chk("walk.pc", 32'(pc), ENDA);
        chk("walk.done", 32'(done), 1);
        chk("walk.run", 32'(run), 0);

        // Jumps
        lut_write(2, 12'hFFD);
        lut_write(5, 40);
        req = 1;
        step("restart");
        for (int i = 0; i < 10; i++) step("to10");
        relj = 1; lut_idx = 2;
        step("relj");
        chk("relj.pc", 32'(pc), 7);
        step("to8");
        absj = 1; lut_idx = 5;
        step("absj");
        chk("absj.pc", 32'(pc), 40);
        absj = 1; relj = 1; lut_idx = 5;
        step("absrel");
        chk("absrel.pc", 32'(pc), 40);

        // Halt, hold, restart
        lut_write(1, 17);
        absj = 1; lut_idx = 1;
        step("to17");
        halt = 1;
        step("halt");
        chk("halt.pc", 32'(pc), 17);
        chk("halt.done", 32'(done), 1);
        step("hold");
        chk("hold.done", 32'(done), 1);
        req = 1;
        step("rehalt");
        chk("rehalt.pc", 32'(pc), 0);
        chk("rehalt.cyc", 32'(cyc), 0);

        // Call/return
        lut_write(3, 100);
        lut_write(4, 200);
`ifdef FETCH_SEQ_CALL_STACK_EN
        call_en = 1; lut_idx = 3; step("call1");
        chk("call1.pc", 32'(pc), 100);
        step("c1inc");
        call_en = 1; lut_idx = 4; step("call2");
        chk("call2.pc", 32'(pc), 200);
        step("c2inc");
        ret_en = 1; call_en = 1; lut_idx = 3; step("ret1");
        chk("ret1.pc", 32'(pc), 102);
        ret_en = 1; step("ret2");
        chk("ret2.pc", 32'(pc), 3);
        call_en = 1; lut_idx = 3; step("callA");
        call_en = 1; lut_idx = 4; step("callB");
        call_en = 1; lut_idx = 3; step("callC");
        chk("ovf.pc", 32'(pc), 200);
        chk("ovf.fault", 32'(fault), 1);
        chk("ovf.done", 32'(done), 1);
        req = 1; step("reovf");
        chk("reovf.fault", 32'(fault), 0);
        ret_en = 1; step("udf");
        chk("udf.pc", 32'(pc), 0);
        chk("udf.fault", 32'(fault), 1);
`else
        p = m_pc;
        call_en = 1; lut_idx = 3; step("callign");
        chk("callign.pc", 32'(pc), p + 1);
        ret_en = 1; step("retign");
        chk("retign.pc", 32'(pc), p + 2);
        chk("retign.fault", 32'(fault), 0);
`endif

        // Mid-run reset
        if (!m_run) begin req = 1; step("rerun"); end
        lut_write(6, 50);
        absj = 1; lut_idx = 6; step("to50");
        chk("to50.pc", 32'(pc), 50);
        #3;
        rst_n = 0;
        #1;
        model_reset();
        check_model("midrst");
        #1;
        rst_n = 1;
        req = 1; step("postrst");
        chk("postrst.run", 32'(run), 1);
        absj = 1; lut_idx = 6; step("lutclr");
        chk("lutclr.pc", 32'(pc), 0);

        // Watchdog on the 4-bit counter instance
        #2;
        rst_n = 0;
        #2;
        model_reset();
        rst_n = 1;
        req = 1; step("wdstart");
        for (int i = 1; i <= 15; i++) begin
            absj = 1; lut_idx = 0;
            step("wdloop");
            if (i == 14) begin
                chk("wd14.fault", 32'(wd_fault), 0);
                chk("wd14.run", 32'(wd_run), 1);
                chk("wd14.cyc", 32'(wd_cyc), 14);
            end
        end
        chk("wd15.fault", 32'(wd_fault), 1);
        chk("wd15.done", 32'(wd_done), 1);
        chk("wd15.run", 32'(wd_run), 0);
        chk("wd15.cyc", 32'(wd_cyc), 15);
        chk("wd15.pc", 32'(wd_pc), 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            req      = ($urandom_range(0, 3) == 0);
            halt     = ($urandom_range(0, 29) == 0);
            relj     = ($urandom_range(0, 5) == 0);
            absj     = ($urandom_range(0, 7) == 0);
            call_en  = ($urandom_range(0, 7) == 0);
            ret_en   = ($urandom_range(0, 7) == 0);
            lut_idx  = 3'($urandom);
            lut_we   = ($urandom_range(0, 4) == 0);
            lut_widx = 3'($urandom);
            lut_wdat = 12'($urandom);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Parametrised instruction-fetch sequencer: the program counter, the jump-target LUT and the run/done handshake combined into one block, plus an optional call/return stack. It sits between the control decoder and the instruction ROM. `req` starts a program and `done` reports completion, replacing the hard-wired `prog_ctr == 128` test. Jump targets live in a run-time-writable LUT instead of a constant table.

## Interface
- `D`, 12: program counter width.
- `LW`, 3: LUT index width; the LUT has 2**LW entries of D bits.
- `SD`, 4: call-stack depth, in entries.
- `WW`, 16: watchdog/cycle counter width.
- `START_ADDR`, 0: PC load value on reset and on each start.
- `END_ADDR`, 128: PC value that ends a run.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 1: start request, sampled every cycle.
- `halt` in 1: decoded halt instruction.
- `relj` in 1: relative jump; PC <= PC + LUT[`lut_idx`].
- `absj` in 1: absolute jump; PC <= LUT[`lut_idx`].
- `call_en` in 1: call; push PC+1, then PC <= LUT[`lut_idx`].
- `ret_en` in 1: return; PC <= popped value.
- `lut_idx` in LW: LUT read index.
- `lut_we` in 1: LUT write enable.
- `lut_widx` in LW: LUT write index.
- `lut_wdat` in D: LUT write data.
- `prog_ctr` out D: current PC. Reset value `START_ADDR`.
- `run` out 1: high while executing. Reset value 0.
- `done` out 1: run complete. Reset value 0.
- `fault` out 1: stack overflow/underflow or watchdog expiry. Reset value 0.
- `cyc_cnt` out WW: count of RUN cycles in the current run, saturating. Reset value 0.

## Operation
- State machine with three states: IDLE (after reset), RUN, DONE.
- IDLE + `req`: go to RUN. `prog_ctr` is already `START_ADDR`.
- DONE + `req`: go to RUN with these loads:
  - `prog_ctr` <= `START_ADDR`
  - `cyc_cnt`, `fault` and `done` cleared
  - stack emptied
- RUN: `req` is ignored. Control inputs are sampled only in RUN and ignored in IDLE and DONE.
- RUN next-PC selection, highest priority first:
  1. `halt`: PC frozen, go to DONE.
  2. `ret_en`
  3. `call_en`
  4. `absj`
  5. `relj`
  6. otherwise PC+1
- Relative jump: the LUT entry is treated as two's complement D bits. All PC arithmetic is modulo 2**D, so a wrap is silent and is not a fault.
- End of run: if the computed next PC equals `END_ADDR`, the PC loads `END_ADDR` and the state goes to DONE.
- Watchdog:
  - `cyc_cnt` increments on each RUN cycle.
  - When it reaches all-ones it saturates, `fault` is set and the state goes to DONE.
- LUT writes are accepted in any state.
  - A write and a read to the same index in the same cycle returns the old value.
  - The LUT resets to all zeros.
- Asserting `reset` mid-run puts the block back in IDLE with all outputs at their reset values and the stack empty.

## Timing
- All state changes occur on the rising edge of `clk`; `reset` acts immediately.
- `run` and `done` are registered outputs and are one-hot with the IDLE condition.
- `req` asserted at edge N: `run` = 1 after edge N, and the first instruction address is presented during cycle N+1.
- Each RUN cycle advances the PC exactly once; jumps take zero extra cycles.
- A terminating condition at edge M gives `run` = 0 and `done` = 1 after edge M. `done` holds until the next accepted `req`.
- `fault` is set in the same edge as the DONE transition that it causes.

## Configuration
- Macro: `FETCH_SEQ_CALL_STACK_EN`.
- Defined: SD-entry LIFO is present.
  - A push when the stack is full, or a pop when it is empty, sets `fault` and goes to DONE. The PC and the stack are unchanged.
  - `call_en` and `ret_en` in the same cycle: `ret_en` wins and no push occurs.
- Undefined:
  - No stack storage.
  - `call_en` and `ret_en` are ignored, and the cycle falls through to the next priority.
  - `fault` arises from the watchdog only.

## Structure
- `fetch_pkg` holds:
  - the state enum (`IDLE`, `RUN`, `DONE`)
  - the next-PC select enum
  - the default parameter constants
- One sub-module, `fetch_stack`: parametrised LIFO (D, SD) with push/pop, full/empty and flush. It is instantiated only under the macro.

## Test plan
- **Reset and start:** pulse `reset` low, then `req` for one cycle.
  - After reset: `prog_ctr` = 0, `run` = 0, `done` = 0.
  - Then `run` = 1, and the PC walks 0, 1, 2, … to 128.
  - After that: `done` = 1, `run` = 0.
- **Jumps:** write LUT[2] = 0xFFD (i.e. −3) and LUT[5] = 40.
  - `relj` at PC = 10 gives PC 7.
  - `absj` at PC = 8 gives PC 40.
  - `relj` and `absj` together apply the absolute jump.
- **Halt and restart:** `halt` at PC = 17 freezes the PC at 17 with `done` = 1. A second `req` restarts at 0 with `cyc_cnt` = 0.
- **Watchdog:** WW = 4 with a tight loop (`absj` to self). `fault` = 1 and `done` = 1 after 15 RUN cycles.
- **Call stack (macro on), SD = 2:**
  - Two calls followed by two returns restore PC+1 of each call site in order.
  - A third nested call sets `fault` with the PC unchanged.
  - A `ret_en` on an empty stack sets `fault`.
- **Mid-run reset:** assert `reset` at PC = 50. Outputs return to reset values immediately; `req` then starts again from 0.
